// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions for the master-side bus interface and its address decoder.
package bus_master_if_pkg;

    localparam int   DATA_WIDTH      = 32;
    localparam int   BUS_SLAVE_IDX_W = 3;
    localparam int   NUM_SLAVES      = 1 << BUS_SLAVE_IDX_W;

    localparam logic CS_ENABLE  = 1'b1;
    localparam logic CS_DISABLE = 1'b0;
    localparam logic HIGH       = 1'b1;
    localparam logic LOW        = 1'b0;
    localparam logic BUS_READ   = 1'b1;

endpackage

// File: rtl/bus_master_if_addr_dec.sv
// Slave index to one-hot chip-select decoder; all selects idle when not enabled.
module bus_addr_dec
    import bus_master_if_pkg::*;
(
    input  logic [BUS_SLAVE_IDX_W-1:0] idx_i,
    input  logic                       en_i,
    output logic [NUM_SLAVES-1:0]      cs_o
);

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_cs
        assign cs_o[g] = (en_i && (idx_i == BUS_SLAVE_IDX_W'(g))) ? CS_ENABLE : CS_DISABLE;
    end

endmodule

// File: rtl/bus_master_if.sv
// Master-side bus interface: arbitrates for the slave bus, strobes one access per CPU
// load/store and returns read data, or an error pulse if the slave never answers.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  cpu_req,
    input  logic                  cpu_rw,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wr_data,
    output logic [DATA_W-1:0]     cpu_rd_data,
    output logic                  cpu_busy,
    output logic                  cpu_err,
    output logic                  bus_req,
    input  logic                  bus_grnt,
    output logic                  bus_as_,
    output logic                  bus_rw,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wr_data,
    output logic [NUM_SLAVES-1:0] s_cs,
    input  logic [DATA_W-1:0]     s_rd_data,
    input  logic                  s_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              err_q, err_d;
    logic              done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cpu_req) begin
                    state_d = S_REQ;
                    rw_d    = cpu_rw;
                    addr_d  = cpu_addr;
                    wd_d    = cpu_wr_data;
                end
            end
            S_REQ: begin
                if (bus_grnt) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS, S_WAIT: begin
                // Ready is tested first so a reply on the last allowed cycle still completes.
                if (s_ready) begin
                    done = 1'b1;
                    if (rw_q == BUS_READ) rd_d = s_rd_data;
                end else if (cnt_q == CNT_LAST) begin
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Bus outputs return to their idle values whenever a transfer ends.
        if (done) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rw_d    = BUS_READ;
            addr_d  = '0;
            wd_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= BUS_READ;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign cpu_busy    = (state_q != S_IDLE);
    assign cpu_err     = err_q;
    assign cpu_rd_data = rd_q;
    assign bus_req     = cpu_busy ? HIGH : LOW;
    assign bus_as_     = (state_q == S_ACCESS) ? LOW : HIGH;
    assign bus_rw      = rw_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wd_q;

    bus_addr_dec u_dec (
        .idx_i (addr_q[ADDR_W-1 -: BUS_SLAVE_IDX_W]),
        .en_i  ((state_q == S_ACCESS) || (state_q == S_WAIT)),
        .cs_o  (s_cs)
    );

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if with a transaction-level reference model checked every cycle.
module tb_bus_master_if;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [29:0] cpu_addr = '0;
    logic [31:0] cpu_wr_data = '0;
    logic [31:0] cpu_rd_data;
    logic        cpu_busy, cpu_err, bus_req, bus_as_, bus_rw;
    logic        bus_grnt = 1'b0;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [7:0]  s_cs;
    logic [31:0] s_rd_data = '0;
    logic        s_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_(reset_),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
        .bus_req(bus_req), .bus_grnt(bus_grnt), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .s_cs(s_cs),
        .s_rd_data(s_rd_data), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Transaction-level model: active transfer, ownership, age since the strobe.
    logic        m_active = 1'b0, m_owned = 1'b0, m_rw = 1'b1, m_err = 1'b0;
    logic [29:0] m_addr = '0;
    logic [31:0] m_wd = '0, m_rd = '0;
    int          m_age = 0;
    logic        m_end;

    initial forever begin
        @(posedge clk or negedge reset_);
        m_end = 1'b0;
        if (!reset_) begin
            m_active = 0; m_owned = 0; m_rw = 1; m_err = 0;
            m_addr = '0; m_wd = '0; m_rd = '0; m_age = 0;
        end else begin
            m_err = 0;
            if (!m_active) begin
                if (cpu_req) begin
                    m_active = 1; m_owned = 0;
                    m_rw = cpu_rw; m_addr = cpu_addr; m_wd = cpu_wr_data;
                end
            end else if (!m_owned) begin
                if (bus_grnt) begin m_owned = 1; m_age = 0; end
            end else if (s_ready) begin
                if (m_rw) m_rd = s_rd_data;
                m_end = 1'b1;
            end else if (m_age == TO - 1) begin
                m_err = 1; m_end = 1'b1;
            end else begin
                m_age++;
            end
            if (m_end) begin
                m_active = 0; m_owned = 0; m_rw = 1; m_addr = '0; m_wd = '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, cpu_busy}, {31'd0, m_active});
        chk("bus_req", {31'd0, bus_req}, {31'd0, m_active});
        chk("err", {31'd0, cpu_err}, {31'd0, m_err});
        chk("as_", {31'd0, bus_as_}, {31'd0, !(m_active && m_owned && m_age == 0)});
        chk("cs", {24'd0, s_cs}, (m_active && m_owned) ? (32'd1 << m_addr[29:27]) : 32'd0);
        chk("bus_rw", {31'd0, bus_rw}, {31'd0, m_rw});
        chk("bus_addr", {2'd0, bus_addr}, {2'd0, m_addr});
        chk("bus_wd", bus_wr_data, m_wd);
        chk("rd_data", cpu_rd_data, m_rd);
    end

    logic [7:0] cs_seen [3];
    logic [29:0] b2b_addr [3];
    int n, nerr, at;

    initial begin
        b2b_addr[0] = {3'd0, 27'h4};
        b2b_addr[1] = {3'd3, 27'h55};
        b2b_addr[2] = {3'd7, 27'h7FF_FFFF};
        repeat (2) tick();
        chk("rst busy", {31'd0, cpu_busy}, 32'd0);
        chk("rst as_", {31'd0, bus_as_}, 32'd1);
        chk("rst rw", {31'd0, bus_rw}, 32'd1);
        chk("rst cs", {24'd0, s_cs}, 32'd0);
        reset_ = 1'b1;
        tick();

        // 1: read, immediate grant and ready; early ready in REQ must be ignored
        cpu_req = 1; cpu_rw = 1; cpu_addr = 30'h0000_0010;
        bus_grnt = 1; s_ready = 1; s_rd_data = 32'hDEAD_BEEF;
        tick(); cpu_req = 0;
        chk("t1 req busy", {31'd0, cpu_busy}, 32'd1);
        chk("t1 req as_", {31'd0, bus_as_}, 32'd1);
        tick();
        chk("t1 as_", {31'd0, bus_as_}, 32'd0);
        chk("t1 cs", {24'd0, s_cs}, 32'h01);
        tick();
        chk("t1 busy", {31'd0, cpu_busy}, 32'd0);
        chk("t1 rd", cpu_rd_data, 32'hDEAD_BEEF);
        bus_grnt = 0; s_ready = 0;

        // 2: write to slave 5, late grant, two waits, grant dropped and stray cpu_req mid-transfer
        cpu_req = 1; cpu_rw = 0; cpu_addr = {3'd5, 27'h100}; cpu_wr_data = 32'h1234_5678;
        tick(); cpu_req = 0;
        repeat (3) tick();
        bus_grnt = 1;
        tick();
        chk("t2 cs", {24'd0, s_cs}, 32'h20);
        chk("t2 rw", {31'd0, bus_rw}, 32'd0);
        bus_grnt = 0;
        tick();
        cpu_req = 1; cpu_addr = '0; cpu_wr_data = 32'hFFFF_0000;
        tick();
        chk("t2 wd", bus_wr_data, 32'h1234_5678);
        chk("t2 addr", {2'd0, bus_addr}, {2'd0, 3'd5, 27'h100});
        cpu_req = 0; s_ready = 1; s_rd_data = 32'hAAAA_5555;
        tick();
        chk("t2 busy", {31'd0, cpu_busy}, 32'd0);
        chk("t2 rd", cpu_rd_data, 32'hDEAD_BEEF);
        s_ready = 0;

        // 3: timeout
        cpu_req = 1; cpu_rw = 1; cpu_addr = {3'd2, 27'h9}; bus_grnt = 1;
        tick(); cpu_req = 0;
        tick();
        chk("t3 as_", {31'd0, bus_as_}, 32'd0);
        nerr = 0; at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cpu_err) begin
                nerr++; at = i;
                chk("t3 bus_req", {31'd0, bus_req}, 32'd0);
                chk("t3 cs", {24'd0, s_cs}, 32'd0);
                chk("t3 addr", {2'd0, bus_addr}, 32'd0);
                chk("t3 rd", cpu_rd_data, 32'hDEAD_BEEF);
            end
        end
        chk("t3 err count", nerr, 32'd1);
        chk("t3 err cycle", at, 32'd8);

        // 4: ready on the last allowed cycle wins over timeout
        cpu_req = 1; cpu_addr = {3'd6, 27'h1};
        tick(); cpu_req = 0;
        tick();
        repeat (TO - 1) tick();
        s_ready = 1; s_rd_data = 32'hCAFE_F00D;
        tick();
        chk("t4 busy", {31'd0, cpu_busy}, 32'd0);
        chk("t4 err", {31'd0, cpu_err}, 32'd0);
        chk("t4 rd", cpu_rd_data, 32'hCAFE_F00D);

        // 5: back-to-back with cpu_req held high
        s_rd_data = 32'h1111_2222; cpu_req = 1; cpu_addr = b2b_addr[0];
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!bus_as_) begin
                if (n < 3) cs_seen[n] = s_cs;
                n++;
                if (n < 3) cpu_addr = b2b_addr[n];
                else cpu_req = 0;
            end
        end
        chk("t5 strobes", n, 32'd3);
        chk("t5 cs0", {24'd0, cs_seen[0]}, 32'h01);
        chk("t5 cs1", {24'd0, cs_seen[1]}, 32'h08);
        chk("t5 cs2", {24'd0, cs_seen[2]}, 32'h80);
        s_ready = 0;

        // 6: asynchronous reset during WAIT, then a fresh read
        cpu_req = 1; cpu_addr = {3'd4, 27'h3};
        tick(); cpu_req = 0;
        tick(); tick();
        #2 reset_ = 0;
        #1;
        chk("t6 busy", {31'd0, cpu_busy}, 32'd0);
        chk("t6 bus_req", {31'd0, bus_req}, 32'd0);
        chk("t6 as_", {31'd0, bus_as_}, 32'd1);
        chk("t6 cs", {24'd0, s_cs}, 32'd0);
        chk("t6 addr", {2'd0, bus_addr}, 32'd0);
        chk("t6 rd", cpu_rd_data, 32'd0);
        tick(); reset_ = 1;
        cpu_req = 1; s_ready = 1; s_rd_data = 32'h0BAD_C0DE;
        tick(); cpu_req = 0;
        tick(); tick();
        chk("t6 busy after", {31'd0, cpu_busy}, 32'd0);
        chk("t6 rd after", cpu_rd_data, 32'h0BAD_C0DE);
        s_ready = 0; bus_grnt = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
